bellman_sched: RTL and testbench

Controller that owns the adjacency-matrix write port and sequences the Bellman engine. Host edge-weight updates are buffered in a small FIFO, applied to the adjacency matrix only while the engine is idle, and relaxation runs are launched on request from a chosen source vertex. It sits between the host register interface and the Bellman/adjmat/vertmat datapath, so the matrix never changes under a running relaxation.

---
 rtl/bellman_sched.sv | 143 ++++++++++++++
 tb/tb_bellman_sched.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bellman_sched.sv
// rtl/bellman_sched.sv - update FIFO + sequencer for the Bellman engine and adjmat write port
// Optional: BELLMAN_AUTO_RUN_EN launches a run from the last source after every drained batch.
module bellman_sched #(
  parameter int NODES      = 8,
  parameter int ADDR_W     = $clog2(NODES),
  parameter int WEIGHT_W   = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                upd_valid,
  output logic                upd_ready,
  input  logic [ADDR_W-1:0]   upd_row,
  input  logic [ADDR_W-1:0]   upd_col,
  input  logic [WEIGHT_W-1:0] upd_weight,
  input  logic                run_req,
  input  logic [ADDR_W-1:0]   run_src,
  output logic                adjmat_we,
  output logic [ADDR_W-1:0]   adjmat_wr_row,
  output logic [ADDR_W-1:0]   adjmat_wr_col,
  output logic [WEIGHT_W-1:0] adjmat_wr_data,
  output logic                bellman_reset,
  output logic [ADDR_W-1:0]   bellman_src,
  input  logic                bellman_done,
  output logic                busy,
  output logic                result_valid,
  output logic [ADDR_W-1:0]   result_src,
  output logic                result_stale
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, RUN, DONE} state_t;

  state_t              state;
  state_t              state_nx;
  logic [ADDR_W-1:0]   row_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]   col_mem [FIFO_DEPTH];
  logic [WEIGHT_W-1:0] wgt_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    count_nx;
  logic                push;
  logic                pop;
  logic                run_pend;
  logic                stale;
  logic [ADDR_W-1:0]   src_q;

  // No pass-through when full: a pop in the same cycle does not open the slot early.
  assign upd_ready = (count != CNT_W'(FIFO_DEPTH));
  assign push      = upd_valid && upd_ready;
  assign pop       = (state == DRAIN) && (count != '0);

  assign adjmat_we      = pop;
  assign adjmat_wr_row  = pop ? row_mem[rd_ptr] : '0;
  assign adjmat_wr_col  = pop ? col_mem[rd_ptr] : '0;
  assign adjmat_wr_data = pop ? wgt_mem[rd_ptr] : '0;

  always_comb begin
    count_nx = count;
    if (push && !pop)
      count_nx = count + 1'b1;
    else if (pop && !push)
      count_nx = count - 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (count != '0)
          state_nx = DRAIN;
        else if (run_pend)
          state_nx = RUN;
      end
      DRAIN: if (count_nx == '0) state_nx = IDLE;
      RUN:   if (bellman_done) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Storage needs no reset; only pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      row_mem[wr_ptr] <= upd_row;
      col_mem[wr_ptr] <= upd_col;
      wgt_mem[wr_ptr] <= upd_weight;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      run_pend      <= 1'b0;
      src_q         <= '0;
      stale         <= 1'b0;
      bellman_reset <= 1'b1;
      bellman_src   <= '0;
      busy          <= 1'b0;
      result_valid  <= 1'b0;
      result_src    <= '0;
      result_stale  <= 1'b0;
    end else begin
      state         <= state_nx;
      count         <= count_nx;
      bellman_reset <= (state_nx != RUN);
      busy          <= (state_nx != IDLE);
      result_valid  <= (state_nx == DONE);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      // The engine source is frozen at launch so later requests cannot disturb a live run.
      if (state == IDLE && state_nx == RUN)
        bellman_src <= src_q;

      if (state == RUN && state_nx == DONE) begin
        result_src   <= bellman_src;
        result_stale <= stale || push;
        stale        <= 1'b0;
      end else if (state == RUN && push) begin
        stale <= 1'b1;
      end

      if (run_req) begin
        run_pend <= 1'b1;
        src_q    <= run_src;
      end else if (state == IDLE && state_nx == RUN) begin
        run_pend <= 1'b0;
`ifdef BELLMAN_AUTO_RUN_EN
      end else if (state == DRAIN && state_nx == IDLE) begin
        run_pend <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_bellman_sched.sv
// tb/tb_bellman_sched.sv - randomized scenario bench for bellman_sched with queue-based reference
module tb_bellman_sched;

  localparam int NODES      = 8;
  localparam int ADDR_W     = 3;
  localparam int WEIGHT_W   = 32;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic [ADDR_W-1:0]   row;
    logic [ADDR_W-1:0]   col;
    logic [WEIGHT_W-1:0] w;
  } upd_t;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                upd_valid = 1'b0;
  logic                upd_ready;
  logic [ADDR_W-1:0]   upd_row = '0;
  logic [ADDR_W-1:0]   upd_col = '0;
  logic [WEIGHT_W-1:0] upd_weight = '0;
  logic                run_req = 1'b0;
  logic [ADDR_W-1:0]   run_src = '0;
  logic                adjmat_we;
  logic [ADDR_W-1:0]   adjmat_wr_row;
  logic [ADDR_W-1:0]   adjmat_wr_col;
  logic [WEIGHT_W-1:0] adjmat_wr_data;
  logic                bellman_reset;
  logic [ADDR_W-1:0]   bellman_src;
  logic                bellman_done = 1'b0;
  logic                busy;
  logic                result_valid;
  logic [ADDR_W-1:0]   result_src;
  logic                result_stale;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int overlap = 0;
  logic prev_bres = 1'b1;

  upd_t              exp_q[$];
  upd_t              wr_q[$];
  int                wr_cyc[$];
  logic [ADDR_W-1:0] res_src_q[$];
  logic              res_stale_q[$];
  int                res_cyc[$];
  int                run_start[$];
  int                wb, rb, sb, ob;
  logic [ADDR_W-1:0] last_src = '0;

  bellman_sched #(
    .NODES(NODES), .ADDR_W(ADDR_W), .WEIGHT_W(WEIGHT_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_row(upd_row), .upd_col(upd_col), .upd_weight(upd_weight),
    .run_req(run_req), .run_src(run_src),
    .adjmat_we(adjmat_we), .adjmat_wr_row(adjmat_wr_row),
    .adjmat_wr_col(adjmat_wr_col), .adjmat_wr_data(adjmat_wr_data),
    .bellman_reset(bellman_reset), .bellman_src(bellman_src), .bellman_done(bellman_done),
    .busy(busy), .result_valid(result_valid), .result_src(result_src),
    .result_stale(result_stale)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed-event log: writes, result pulses and run launches, stamped by edge index.
  always @(negedge clk) begin
    if (adjmat_we) begin
      wr_q.push_back({adjmat_wr_row, adjmat_wr_col, adjmat_wr_data});
      wr_cyc.push_back(cyc);
      if (!bellman_reset) overlap <= overlap + 1;
    end
    if (result_valid) begin
      res_src_q.push_back(result_src);
      res_stale_q.push_back(result_stale);
      res_cyc.push_back(cyc);
    end
    if (prev_bres && !bellman_reset) run_start.push_back(cyc);
    prev_bres <= bellman_reset;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic upd_t mk(input int r, input int c, input int w);
    upd_t m;
    m.row = ADDR_W'(r);
    m.col = ADDR_W'(c);
    m.w   = WEIGHT_W'(w);
    return m;
  endfunction

  function automatic upd_t rand_upd();
    upd_t m;
    m.row = ADDR_W'($urandom_range(0, NODES - 1));
    m.col = ADDR_W'($urandom_range(0, NODES - 1));
    m.w   = ($urandom_range(0, 3) == 0) ? '0 : WEIGHT_W'($urandom);
    return m;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mark();
    wb = wr_q.size();
    rb = res_src_q.size();
    sb = run_start.size();
    ob = overlap;
    exp_q.delete();
  endtask

  task automatic push(input upd_t u);
    logic rdy;
    upd_valid  = 1'b1;
    upd_row    = u.row;
    upd_col    = u.col;
    upd_weight = u.w;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      rdy = upd_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        exp_q.push_back(u);
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL push_timeout got=no_accept exp=accept");
  endtask

  task automatic pulse_run(input logic [ADDR_W-1:0] s);
    run_req = 1'b1;
    run_src = s;
    step(1);
    run_req = 1'b0;
  endtask

  // Waits for the block to go quiet, acting as an engine that finishes any run after 3 cycles.
  task automatic settle();
    int quiet = 0;
    int inrun = 0;
    for (int k = 0; k < 400; k++) begin
      step(1);
      bellman_done = 1'b0;
      if (!bellman_reset) begin
        inrun++;
        if (inrun == 3) bellman_done = 1'b1;
      end else begin
        inrun = 0;
      end
      if (!busy) quiet++; else quiet = 0;
      if (quiet >= 4) return;
    end
    total++;
    bad++;
    $display("FAIL settle_timeout got=busy exp=idle");
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(3);
    total++; if (bellman_reset !== 1'b1) begin bad++; $display("FAIL rst_bellman_reset got=%b exp=1", bellman_reset); end
    total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL rst_upd_ready got=%b exp=1", upd_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (adjmat_we !== 1'b0) begin bad++; $display("FAIL rst_adjmat_we got=%b exp=0", adjmat_we); end
    total++; if ({adjmat_wr_row, adjmat_wr_col, adjmat_wr_data} !== '0) begin bad++; $display("FAIL rst_adjmat_bus got=%0h exp=0", {adjmat_wr_row, adjmat_wr_col, adjmat_wr_data}); end
    total++; if (bellman_src !== '0) begin bad++; $display("FAIL rst_bellman_src got=%0d exp=0", bellman_src); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL rst_result_valid got=%b exp=0", result_valid); end
    total++; if (result_src !== '0) begin bad++; $display("FAIL rst_result_src got=%0d exp=0", result_src); end
    total++; if (result_stale !== 1'b0) begin bad++; $display("FAIL rst_result_stale got=%b exp=0", result_stale); end
    reset_n = 1'b1;
    last_src = '0;
    step(2);
  endtask

  task automatic test_drain();
    upd_t u;
    int n;
    int t0;
    int nw;
    for (int r = 0; r < 5; r++) begin
      mark();
      n  = (r == 0) ? 3 : $urandom_range(1, FIFO_DEPTH);
      t0 = cyc;
      for (int i = 0; i < n; i++) begin
        if (r == 0)
          u = (i == 0) ? mk(0, 1, -5) : (i == 1) ? mk(1, 2, 7) : mk(2, 0, 3);
        else
          u = rand_upd();
        push(u);
      end
      upd_valid = 1'b0;
      settle();
      nw = wr_q.size() - wb;
      total++; if (nw !== n) begin bad++; $display("FAIL drain_count round=%0d got=%0d exp=%0d", r, nw, n); end
      for (int i = 0; i < n && i < nw; i++) begin
        total++; if (wr_q[wb+i] !== exp_q[i]) begin bad++; $display("FAIL drain_data round=%0d idx=%0d got=%0h exp=%0h", r, i, wr_q[wb+i], exp_q[i]); end
        total++; if (wr_cyc[wb+i] !== t0 + 2 + i) begin bad++; $display("FAIL drain_cycle round=%0d idx=%0d got=%0d exp=%0d", r, i, wr_cyc[wb+i], t0 + 2 + i); end
      end
`ifdef BELLMAN_AUTO_RUN_EN
      total++; if (res_src_q.size() - rb !== 1) begin bad++; $display("FAIL drain_autorun got=%0d exp=1", res_src_q.size() - rb); end
      else begin
        total++; if (res_src_q[rb] !== last_src) begin bad++; $display("FAIL drain_autorun_src got=%0d exp=%0d", res_src_q[rb], last_src); end
      end
`else
      total++; if (res_src_q.size() - rb !== 0) begin bad++; $display("FAIL drain_no_run got=%0d exp=0", res_src_q.size() - rb); end
`endif
    end
  endtask

  task automatic test_run();
    logic [ADDR_W-1:0] s;
    int t0;
    int td;
    for (int r = 0; r < 3; r++) begin
      mark();
      s  = (r == 0) ? ADDR_W'(2) : ADDR_W'($urandom_range(0, NODES - 1));
      t0 = cyc;
      pulse_run(s);
      last_src = s;
      step(1 + $urandom_range(1, 4));
      total++; if (run_start.size() - sb !== 1) begin bad++; $display("FAIL run_launch got=%0d exp=1", run_start.size() - sb); end
      else begin
        total++; if (run_start[sb] !== t0 + 2) begin bad++; $display("FAIL run_start_cycle got=%0d exp=%0d", run_start[sb], t0 + 2); end
      end
      total++; if (bellman_reset !== 1'b0) begin bad++; $display("FAIL run_reset_low got=%b exp=0", bellman_reset); end
      total++; if (bellman_src !== s) begin bad++; $display("FAIL run_src got=%0d exp=%0d", bellman_src, s); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL run_busy got=%b exp=1", busy); end
      bellman_done = 1'b1;
      td = cyc;
      step(1);
      bellman_done = 1'b0;
      step(4);
      total++; if (res_src_q.size() - rb !== 1) begin bad++; $display("FAIL run_result_pulses got=%0d exp=1", res_src_q.size() - rb); end
      else begin
        total++; if (res_src_q[rb] !== s) begin bad++; $display("FAIL run_result_src got=%0d exp=%0d", res_src_q[rb], s); end
        total++; if (res_stale_q[rb] !== 1'b0) begin bad++; $display("FAIL run_result_stale got=%b exp=0", res_stale_q[rb]); end
        total++; if (res_cyc[rb] !== td + 1) begin bad++; $display("FAIL run_result_cycle got=%0d exp=%0d", res_cyc[rb], td + 1); end
      end
      total++; if (bellman_reset !== 1'b1) begin bad++; $display("FAIL run_reset_after got=%b exp=1", bellman_reset); end
      settle();
    end
  endtask

  task automatic test_during_run();
    logic [ADDR_W-1:0] s;
    int nw;
    mark();
    s = ADDR_W'($urandom_range(0, NODES - 1));
    pulse_run(s);
    last_src = s;
    step(2);
    for (int i = 0; i < 4; i++) push(rand_upd());
    total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", upd_ready); end
    fork
      push(rand_upd());
      begin
        step(3);
        total++; if (upd_ready !== 1'b0) begin bad++; $display("FAIL full_hold got=%b exp=0", upd_ready); end
        bellman_done = 1'b1;
        step(1);
        bellman_done = 1'b0;
      end
    join
    upd_valid = 1'b0;
    settle();
    nw = wr_q.size() - wb;
    total++; if (overlap - ob !== 0) begin bad++; $display("FAIL write_during_run got=%0d exp=0", overlap - ob); end
    total++; if (nw !== 5) begin bad++; $display("FAIL run_drain_count got=%0d exp=5", nw); end
    for (int i = 0; i < 5 && i < nw; i++) begin
      total++; if (wr_q[wb+i] !== exp_q[i]) begin bad++; $display("FAIL run_drain_data idx=%0d got=%0h exp=%0h", i, wr_q[wb+i], exp_q[i]); end
    end
`ifdef BELLMAN_AUTO_RUN_EN
    total++; if (res_src_q.size() - rb !== 2) begin bad++; $display("FAIL stale_results got=%0d exp=2", res_src_q.size() - rb); end
`else
    total++; if (res_src_q.size() - rb !== 1) begin bad++; $display("FAIL stale_results got=%0d exp=1", res_src_q.size() - rb); end
`endif
    if (res_src_q.size() > rb) begin
      total++; if (res_stale_q[rb] !== 1'b1) begin bad++; $display("FAIL stale_flag got=%b exp=1", res_stale_q[rb]); end
      total++; if (res_src_q[rb] !== s) begin bad++; $display("FAIL stale_src got=%0d exp=%0d", res_src_q[rb], s); end
      if (nw > 0) begin
        total++; if (wr_cyc[wb] <= res_cyc[rb]) begin bad++; $display("FAIL drain_after_done got=%0d exp=>%0d", wr_cyc[wb], res_cyc[rb]); end
      end
    end
  endtask

  task automatic test_concurrent();
    logic [ADDR_W-1:0] s;
    upd_t u;
    int t0;
    mark();
    s = ADDR_W'($urandom_range(0, NODES - 1));
    u = rand_upd();
    t0 = cyc;
    run_req = 1'b1;
    run_src = s;
    push(u);
    run_req = 1'b0;
    upd_valid = 1'b0;
    last_src = s;
    settle();
    total++; if (wr_q.size() - wb !== 1) begin bad++; $display("FAIL conc_writes got=%0d exp=1", wr_q.size() - wb); end
    else begin
      total++; if (wr_q[wb] !== u) begin bad++; $display("FAIL conc_data got=%0h exp=%0h", wr_q[wb], u); end
      total++; if (wr_cyc[wb] !== t0 + 2) begin bad++; $display("FAIL conc_write_cycle got=%0d exp=%0d", wr_cyc[wb], t0 + 2); end
      if (run_start.size() > sb) begin
        total++; if (run_start[sb] <= wr_cyc[wb]) begin bad++; $display("FAIL conc_order got=%0d exp=>%0d", run_start[sb], wr_cyc[wb]); end
      end
    end
    total++; if (res_src_q.size() - rb !== 1) begin bad++; $display("FAIL conc_results got=%0d exp=1", res_src_q.size() - rb); end
    else begin
      total++; if (res_src_q[rb] !== s) begin bad++; $display("FAIL conc_src got=%0d exp=%0d", res_src_q[rb], s); end
    end

    mark();
    push(rand_upd());
    upd_valid = 1'b0;
    settle();
    total++; if (wr_q.size() - wb !== 1) begin bad++; $display("FAIL single_writes got=%0d exp=1", wr_q.size() - wb); end
`ifdef BELLMAN_AUTO_RUN_EN
    total++; if (res_src_q.size() - rb !== 1) begin bad++; $display("FAIL auto_results got=%0d exp=1", res_src_q.size() - rb); end
    else begin
      total++; if (res_src_q[rb] !== last_src) begin bad++; $display("FAIL auto_src got=%0d exp=%0d", res_src_q[rb], last_src); end
    end
`else
    total++; if (run_start.size() - sb !== 0) begin bad++; $display("FAIL no_auto_run got=%0d exp=0", run_start.size() - sb); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] s1;
    logic [ADDR_W-1:0] s2;
    int td;
    mark();
    s1 = ADDR_W'($urandom_range(0, NODES - 1));
    s2 = ADDR_W'($urandom_range(0, NODES - 1));
    pulse_run(s1);
    step(2);
    pulse_run(s2);
    step(1);
    total++; if (bellman_src !== s1) begin bad++; $display("FAIL b2b_src_stable got=%0d exp=%0d", bellman_src, s1); end
    bellman_done = 1'b1;
    td = cyc;
    step(1);
    bellman_done = 1'b0;
    settle();
    last_src = s2;
    total++; if (res_src_q.size() - rb !== 2) begin bad++; $display("FAIL b2b_results got=%0d exp=2", res_src_q.size() - rb); end
    else begin
      total++; if (res_src_q[rb] !== s1) begin bad++; $display("FAIL b2b_src1 got=%0d exp=%0d", res_src_q[rb], s1); end
      total++; if (res_src_q[rb+1] !== s2) begin bad++; $display("FAIL b2b_src2 got=%0d exp=%0d", res_src_q[rb+1], s2); end
      total++; if (res_cyc[rb] !== td + 1) begin bad++; $display("FAIL b2b_done_cycle got=%0d exp=%0d", res_cyc[rb], td + 1); end
    end
    total++; if (run_start.size() - sb !== 2) begin bad++; $display("FAIL b2b_launches got=%0d exp=2", run_start.size() - sb); end
    else begin
      total++; if (run_start[sb+1] !== td + 3) begin bad++; $display("FAIL b2b_relaunch got=%0d exp=%0d", run_start[sb+1], td + 3); end
    end
  endtask

  task automatic test_reset_mid_run();
    mark();
    pulse_run(ADDR_W'($urandom_range(1, NODES - 1)));
    step(2);
    push(rand_upd());
    push(rand_upd());
    upd_valid = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    total++; if (bellman_reset !== 1'b1) begin bad++; $display("FAIL async_bellman_reset got=%b exp=1", bellman_reset); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL async_busy got=%b exp=0", busy); end
    total++; if (upd_ready !== 1'b1) begin bad++; $display("FAIL async_upd_ready got=%b exp=1", upd_ready); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    last_src = '0;
    step(12);
    total++; if (wr_q.size() - wb !== 0) begin bad++; $display("FAIL post_reset_writes got=%0d exp=0", wr_q.size() - wb); end
    total++; if (res_src_q.size() - rb !== 0) begin bad++; $display("FAIL post_reset_results got=%0d exp=0", res_src_q.size() - rb); end
    total++; if (run_start.size() - sb !== 1) begin bad++; $display("FAIL post_reset_runs got=%0d exp=1", run_start.size() - sb); end
    total++; if (bellman_reset !== 1'b1) begin bad++; $display("FAIL post_reset_idle got=%b exp=1", bellman_reset); end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_run();
    test_during_run();
    test_concurrent();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
